sha256d_nonce_scheduler: RTL
============================

// Module: sha256d_nonce_scheduler
// PURPOSE
//  Mining controller that drives one sha256d_wrapper engine. Holds the 80-byte block header,
//  answers the engine's word-fetch bus and inserts the running nonce at word 19.
//  Sweeps nonces from nonce_start to nonce_end and compares each double hash against target.
//  Reports the first hit (found) or reports that the range is used up (exhausted).
//  Sits between the host/config logic and the hashing core.
// PARAMETERS
//  NONCE_STEP  1    nonce increment per hash (lets several cores split one range)
//  CNT_W       48   width of hash_count (only with MINER_STATS_EN)
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous active-low reset
//  cfg_we       in   1    header word write strobe; ignored while busy=1
//  cfg_addr     in   5    header word index 0..19; 20..31 ignored
//  cfg_wdata    in   32   header word, SHA big-endian word order
//  target       in   256  difficulty target; must be stable while busy
//  nonce_start  in   32   first nonce; sampled on go
//  nonce_end    in   32   last nonce (inclusive); sampled on go
//  go           in   1    one-cycle pulse: start a sweep; ignored while busy
//  stop         in   1    one-cycle pulse: abort the sweep
//  busy         out  1    sweep in progress
//  found        out  1    sticky: a hash <= target was seen
//  exhausted    out  1    sticky: range finished with no hit
//  found_nonce  out  32   nonce that produced the hit
//  found_hash   out  256  engine hash for that hit
//  sha_start    out  1    one-cycle start pulse to the engine
//  sha_rq       in   1    engine word request
//  sha_addr     in   5    requested word index
//  sha_data     out  32   requested word
//  sha_rdy      out  1    sha_data valid
//  sha_hash     in   256  engine result
//  sha_done     in   1    one-cycle pulse per finished double hash
//  hash_count   out  CNT_W  completed hashes (MINER_STATS_EN only)
// BEHAVIOUR
//  Reset: every output is 0; FSM=IDLE; header registers are 0.
//  FSM states: IDLE -> START (one cycle, sha_start=1) -> WAIT (until sha_done) -> CHECK (one cycle) -> START, or -> IDLE.
//  go in IDLE: latch nonce_start/nonce_end, clear found/exhausted, enter START. busy=1 from the next cycle.
//  Fetch bus: sha_rdy<=sha_rq; sha_data<=word[sha_addr] (registered, 1-cycle latency).
//    Word 19 returns the byte-swapped nonce {n[7:0],n[15:8],n[23:16],n[31:24]}.
//    Addresses 20..31 return 0. sha_rdy drops the cycle after sha_rq drops.
//  Compare: value = byte-reverse of sha_hash (Bitcoin little-endian). Hit when value <= target (unsigned).
//  CHECK outcomes:
//    - hit: found=1, store found_nonce/found_hash, go to IDLE.
//    - nonce==nonce_end: exhausted=1, go to IDLE.
//    - otherwise: nonce += NONCE_STEP mod 2^32, go to START.
//  A wrapping range (end < start) is legal; it sweeps through 0xFFFFFFFF -> 0.
//  With NONCE_STEP>1, exhausted is set when the next step would pass nonce_end.
//  stop in START or WAIT sets abort. The in-flight hash is allowed to finish; on sha_done,
//    go to IDLE with no compare and no flag update. stop in IDLE has no effect.
//  go and stop in the same cycle: stop wins, the sweep is not started.
//  A sha_done outside WAIT is ignored. cfg writes with busy=1 are dropped.
//  busy falls in the cycle the FSM re-enters IDLE; found/exhausted are valid in that same cycle.
// CONFIGURATION
//  MINER_STATS_EN defined: hash_count increments on every sha_done in WAIT (including the aborted hash),
//    saturates at all-ones, clears only on reset.
//  MINER_STATS_EN undefined: hash_count port and its logic are absent.
// STRUCTURE
//  miner_pkg: FSM state encodings, HDR_WORDS=20, NONCE_WORD=19, byte-swap function.
//  Sub-module hash_target_cmp: byte reversal plus 256-bit <= compare, registered once in CHECK.
// TESTING
//  1. Genesis header, nonce_start=nonce_end=0x7C2BAC1D, target=0x00000000FFFF<<208
//     -> found=1, found_nonce=0x7C2BAC1D,
//        reversed hash=000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
//  2. Genesis header, range 0x7C2BAC1B..0x7C2BAC1F, same target
//     -> exactly 3 sha_start pulses, found_nonce=0x7C2BAC1D.
//  3. target=0, range 0xFFFFFFFF..0x00000001 -> 3 hashes, nonces FFFFFFFF,0,1; exhausted=1, found=0.
//  4. target=all-ones -> found on the first hash, found_nonce=nonce_start, busy low after 1 hash.
//  5. stop during WAIT -> no further sha_start, busy=0 after sha_done, found=exhausted=0.
//  6. Bus check: sha_rq at addr 19 -> sha_rdy next cycle, sha_data=byte-swapped nonce;
//     cfg_we while busy -> header unchanged.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and helpers for the nonce scheduler: FSM encoding, header geometry, byte swaps.
package miner_pkg;

    localparam int unsigned HDR_WORDS  = 20;
    localparam int unsigned NONCE_WORD = 19;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StCheck
    } state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[255-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Registers whether the byte-reversed (little-endian) engine hash is <= target.
module hash_target_cmp
    import miner_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [255:0] hash,
    input  logic [255:0] target,
    output logic         hit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else if (en) begin
            hit <= (bswap256(hash) <= target);
        end
    end

endmodule

// File: rtl/sha256d_nonce_scheduler.sv
// Nonce sweep controller for one sha256d engine: header store, fetch bus, hit/exhaust tracking.
// Optional hash counter is built when MINER_STATS_EN is defined.
module sha256d_nonce_scheduler
    import miner_pkg::*;
#(
    parameter int unsigned NONCE_STEP = 1
`ifdef MINER_STATS_EN
    ,
    parameter int unsigned CNT_W = 48
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    input  logic [255:0]       target,
    input  logic [31:0]        nonce_start,
    input  logic [31:0]        nonce_end,
    input  logic               go,
    input  logic               stop,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [31:0]        found_nonce,
    output logic [255:0]       found_hash,
    output logic               sha_start,
    input  logic               sha_rq,
    input  logic [4:0]         sha_addr,
    output logic [31:0]        sha_data,
    output logic               sha_rdy,
    input  logic [255:0]       sha_hash,
    input  logic               sha_done
`ifdef MINER_STATS_EN
    ,
    output logic [CNT_W-1:0]   hash_count
`endif
);

    state_e       state_q;
    logic [31:0]  hdr_q [NONCE_WORD];
    logic [31:0]  nonce_q;
    logic [31:0]  nonce_end_q;
    logic         abort_q;
    logic [255:0] hash_q;
    logic         hit;
    logic         done_in_wait;
    logic [31:0]  remaining;
    logic         last;
    logic [31:0]  fetch_word;

    assign done_in_wait = (state_q == StWait) && sha_done;
    // Distance to the inclusive end, modulo 2^32, so wrapping ranges need no special case.
    assign remaining    = nonce_end_q - nonce_q;
    assign last         = remaining < 32'(NONCE_STEP);

    hash_target_cmp u_cmp (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (done_in_wait),
        .hash   (sha_hash),
        .target (target),
        .hit    (hit)
    );

    always_comb begin
        fetch_word = '0;
        if (sha_addr < 5'(NONCE_WORD)) begin
            fetch_word = hdr_q[sha_addr];
        end else if (sha_addr < 5'(HDR_WORDS)) begin
            fetch_word = bswap32(nonce_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NONCE_WORD; i++) begin
                hdr_q[i] <= '0;
            end
            sha_rdy  <= 1'b0;
            sha_data <= '0;
        end else begin
            sha_rdy  <= sha_rq;
            sha_data <= fetch_word;
            // Word 19 is always served from the nonce counter, so it is not stored.
            if (cfg_we && !busy && (cfg_addr < 5'(NONCE_WORD))) begin
                hdr_q[cfg_addr] <= cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            sha_start   <= 1'b0;
            nonce_q     <= '0;
            nonce_end_q <= '0;
            abort_q     <= 1'b0;
            hash_q      <= '0;
        end else begin
            sha_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go && !stop) begin
                        nonce_q     <= nonce_start;
                        nonce_end_q <= nonce_end;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        abort_q     <= 1'b0;
                        busy        <= 1'b1;
                        sha_start   <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (stop) abort_q <= 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    if (stop) abort_q <= 1'b1;
                    if (sha_done) begin
                        hash_q <= sha_hash;
                        if (abort_q || stop) begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (hit) begin
                        found       <= 1'b1;
                        found_nonce <= nonce_q;
                        found_hash  <= hash_q;
                        busy        <= 1'b0;
                        state_q     <= StIdle;
                    end else if (last) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        nonce_q   <= nonce_q + 32'(NONCE_STEP);
                        sha_start <= 1'b1;
                        state_q   <= StStart;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MINER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_count <= '0;
        end else if (done_in_wait && (hash_count != '1)) begin
            hash_count <= hash_count + 1'b1;
        end
    end
`endif

endmodule
